// File: rtl/prim_alert_pkg.sv
// rtl/prim_alert_pkg.sv - differential alert signalling types
package prim_alert_pkg;

  typedef struct packed {
    logic ping_p;
    logic ping_n;
    logic ack_p;
    logic ack_n;
  } alert_rx_t;

  typedef struct packed {
    logic alert_p;
    logic alert_n;
  } alert_tx_t;

endpackage

// File: rtl/prim_diff_decode.sv
// rtl/prim_diff_decode.sv - differential pair decoder with level, edge event and integrity flag
module prim_diff_decode #(
  parameter bit AsyncOn = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic diff_pi,
  input  logic diff_ni,
  output logic level_o,
  output logic event_o,
  output logic sigint_o
);

  logic diff_p, diff_n, equal_pair, level_q;

  if (AsyncOn) begin : gen_async
    logic [1:0] sync_p, sync_n;
    logic       equal_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync_p  <= 2'b00;
        sync_n  <= 2'b11;
        equal_q <= 1'b0;
      end else begin
        sync_p  <= {sync_p[0], diff_pi};
        sync_n  <= {sync_n[0], diff_ni};
        equal_q <= equal_pair;
      end
    end

    assign diff_p = sync_p[1];
    assign diff_n = sync_n[1];
    // Rail skew through the synchronisers can give a one-cycle equal pair; only a persistent one is a fault.
    assign sigint_o = equal_pair & equal_q;
  end else begin : gen_sync
    assign diff_p   = diff_pi;
    assign diff_n   = diff_ni;
    assign sigint_o = equal_pair;
  end

  assign equal_pair = ~(diff_p ^ diff_n);
  assign level_o    = equal_pair ? level_q : diff_p;
  assign event_o    = level_o ^ level_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) level_q <= 1'b0;
    else         level_q <= level_o;
  end

endmodule

// File: rtl/prim_alert_sender_mc.sv
// rtl/prim_alert_sender_mc.sv - multi-source alert sender sharing one differential handshake
module prim_alert_sender_mc
  import prim_alert_pkg::*;
#(
  parameter int NumAlerts   = 4,
  parameter int PauseCycles = 2,
  parameter bit IsFatal     = 1'b0,
  parameter bit AsyncOn     = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumAlerts-1:0] alert_req_i,
  input  logic                 alert_test_i,
  input  alert_rx_t            alert_rx_i,
  output alert_tx_t            alert_tx_o,
  output logic [NumAlerts-1:0] alert_ack_o,
  output logic                 alert_state_o
);

  typedef enum logic [2:0] {
    Idle     = 3'd0,
    HsPhase1 = 3'd1,
    HsPhase2 = 3'd2,
    Pause    = 3'd3,
    SigInt   = 3'd4
  } state_e;

  logic ping_level, ping_event, ping_sigint;
  logic ack_level, ack_event, ack_sigint, sigint;

  prim_diff_decode #(.AsyncOn(AsyncOn)) u_ping_dec (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .diff_pi  (alert_rx_i.ping_p),
    .diff_ni  (alert_rx_i.ping_n),
    .level_o  (ping_level),
    .event_o  (ping_event),
    .sigint_o (ping_sigint)
  );

  prim_diff_decode #(.AsyncOn(AsyncOn)) u_ack_dec (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .diff_pi  (alert_rx_i.ack_p),
    .diff_ni  (alert_rx_i.ack_n),
    .level_o  (ack_level),
    .event_o  (ack_event),
    .sigint_o (ack_sigint)
  );

  logic unused_dec;
  assign unused_dec = ping_level ^ ack_event;
  assign sigint     = ping_sigint | ack_sigint;

  state_e               state_q, state_d;
  logic [NumAlerts-1:0] pending_q, pending_d, served_q, served_d, ack_q, ack_d, req_all;
  logic                 ping_pend_q, ping_pend_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 alert_p_q, alert_p_d, alert_n_q, alert_n_d, state_out_d, state_out_q;

  assign req_all = alert_req_i | NumAlerts'(alert_test_i);

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q | req_all;
    served_d    = served_q;
    ping_pend_d = ping_pend_q | ping_event;
    cnt_d       = cnt_q;
    ack_d       = '0;
    alert_p_d   = 1'b0;
    alert_n_d   = 1'b1;

    case (state_q)
      Idle: begin
        if (|(pending_q | req_all)) begin
          served_d = pending_q | req_all;
          if (!IsFatal) pending_d = '0;
          ping_pend_d = 1'b0;
          state_d     = HsPhase1;
          alert_p_d   = 1'b1;
          alert_n_d   = 1'b0;
        end else if (ping_pend_q || ping_event) begin
          served_d    = '0;
          ping_pend_d = 1'b0;
          state_d     = HsPhase1;
          alert_p_d   = 1'b1;
          alert_n_d   = 1'b0;
        end
      end
      HsPhase1: begin
        if (ack_level) begin
          state_d = HsPhase2;
        end else begin
          alert_p_d = 1'b1;
          alert_n_d = 1'b0;
        end
      end
      HsPhase2: begin
        if (!ack_level) begin
          ack_d    = served_q;
          served_d = '0;
          cnt_d    = 3'(PauseCycles - 1);
          state_d  = Pause;
        end
      end
      Pause: begin
        if (cnt_q == 3'd0) state_d = Idle;
        else               cnt_d   = cnt_q - 3'd1;
      end
      SigInt: begin
        if (sigint) begin
          alert_p_d = ~alert_p_q;
          alert_n_d = ~alert_p_q;
        end else begin
          state_d = Idle;
        end
      end
      default: state_d = Idle;
    endcase

    // Integrity fault wins over everything; alerts of the aborted handshake go back to pending.
    if (sigint && state_q != SigInt) begin
      state_d   = SigInt;
      alert_p_d = 1'b0;
      alert_n_d = 1'b0;
      ack_d     = '0;
      pending_d = pending_q | req_all;
      if (!IsFatal) pending_d = pending_d | served_q;
      served_d  = '0;
      cnt_d     = '0;
    end

    state_out_d = (|pending_d) | ((state_d != Idle) && (state_d != Pause) && (|served_d));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= Idle;
      pending_q   <= '0;
      served_q    <= '0;
      ping_pend_q <= 1'b0;
      cnt_q       <= '0;
      ack_q       <= '0;
      alert_p_q   <= 1'b0;
      alert_n_q   <= 1'b1;
      state_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      served_q    <= served_d;
      ping_pend_q <= ping_pend_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      alert_p_q   <= alert_p_d;
      alert_n_q   <= alert_n_d;
      state_out_q <= state_out_d;
    end
  end

  assign alert_tx_o.alert_p = alert_p_q;
  assign alert_tx_o.alert_n = alert_n_q;
  assign alert_ack_o        = ack_q;
  assign alert_state_o      = state_out_q;

endmodule

// File: doc/prim_alert_sender_mc.md
PRIM_ALERT_SENDER_MC -- requirements
Module: prim_alert_sender_mc

Interface
REQ-001 SHALL have parameter NumAlerts, default 4, number of native alert sources (legal range 1..16).
REQ-002 SHALL have parameter PauseCycles, default 2, number of idle cycles between back-to-back handshakes (legal range 1..8).
REQ-003 SHALL have parameter IsFatal, default 1'b0; when 1, pending alerts are sticky until reset.
REQ-004 SHALL have parameter AsyncOn, default 1'b1, which enables synchronisers in the ping and ack differential decoders.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port alert_req_i, input, NumAlerts bits: per-source native alert request, level-sensitive.
REQ-008 SHALL have port alert_test_i, input, 1 bit: a test request that sets the pending bit of source 0.
REQ-009 SHALL have port alert_rx_i, input, alert_rx_t: the ping_p/ping_n and ack_p/ack_n differential pairs.
REQ-010 SHALL have port alert_tx_o, output, alert_tx_t: the alert_p/alert_n differential pair.
REQ-011 SHALL have port alert_ack_o, output, NumAlerts bits: one-cycle pulse per source whose handshake has completed.
REQ-012 SHALL have port alert_state_o, output, 1 bit: 1 while any alert is pending, or being sent.

Function
REQ-013 SHALL decode ping and ack pairs with prim_diff_decode (AsyncOn passed through); sigint = ping_sigint | ack_sigint.
REQ-014 SHALL keep a pending register per source: set by alert_req_i[i] (and by alert_test_i for i=0), cleared only as stated in REQ-016 and REQ-024.
REQ-015 SHALL keep a ping pending register, set by ping_event and cleared when a handshake starts.
REQ-016 Idle with any pending alert or request (registered or current-cycle) SHALL:
- latch served_mask = pending | alert_req_i (| test on bit 0);
- when IsFatal=0, clear those pending bits;
- clear ping pending;
- go to HsPhase1, driving alert_p=1, alert_n=0 in the next cycle.
REQ-017 Idle with only ping pending or ping_event SHALL:
- set served_mask = 0;
- clear ping pending;
- go to HsPhase1.
REQ-018 HsPhase1 SHALL drive 1/0 until ack_level=1, then go to HsPhase2 driving 0/1.
REQ-019 HsPhase2 SHALL wait for ack_level=0, then pulse alert_ack_o = served_mask for exactly one cycle, load the pause counter with PauseCycles-1 and go to Pause.
REQ-020 Pause SHALL drive 0/1 and decrement the counter, going to Idle when the counter is 0, so that PauseCycles cycles elapse in Pause.
REQ-021 With IsFatal=1, bits in served_mask SHALL remain pending, so handshakes repeat back-to-back indefinitely.
REQ-022 Alerts arriving during a handshake SHALL remain pending and be served by the next handshake, never lost.
REQ-023 Sigint detected in any state other than SigInt SHALL override all other transitions: go to SigInt driving alert_p=alert_n=0, with no pending clear and no alert_ack_o pulse.
REQ-024 On sigint entry with IsFatal=0, bits in served_mask SHALL be re-set in pending so that the alerts are retried.
REQ-025 SigInt SHALL drive alert_p = alert_n = ~alert_p(previous) while sigint persists, and go to Idle driving 0/1 once sigint clears.
REQ-026 alert_tx_o SHALL be registered, with latency exactly one cycle from the FSM decision.
REQ-027 alert_state_o SHALL equal |pending | (state not in {Idle, Pause} and served_mask != 0), registered.
REQ-028 Any unreachable state encoding SHALL return to Idle.

Reset
REQ-029 While rst_ni=0 the block SHALL hold:
- state = Idle;
- alert_p = 0, alert_n = 1;
- alert_ack_o = 0 and alert_state_o = 0;
- pending, ping pending, served_mask and the pause counter all 0.
REQ-030 Reset asserted mid-handshake SHALL abort it immediately, with no alert_ack_o pulse and all pending state lost (including IsFatal=1).

Verification
REQ-031 Scenarios (AsyncOn=0, NumAlerts=4, PauseCycles=2, IsFatal=0 unless stated):
- alert_req_i = 4'b0100 for 1 cycle in Idle -> next cycle alert_p/n = 1/0; ack raised -> 0/1; ack dropped -> alert_ack_o = 4'b0100 for 1 cycle, then 2 Pause cycles, then Idle.
- alert_req_i[1] asserted during HsPhase2 -> after ack_o = 4'b0000 plus 2 Pause cycles, a second handshake with alert_ack_o = 4'b0010.
- Ping pair toggled in Idle with no alerts -> handshake completes with alert_ack_o = 0 and alert_state_o = 0 throughout.
- ack_p = ack_n = 1 during HsPhase1 for 3 cycles -> alert_p = alert_n, toggling 0, 1, 0; after recovery the served alert re-handshakes and alert_ack_o is set for it.
- IsFatal=1, alert_req_i[3] pulsed once -> continuous handshakes, alert_ack_o[3] pulsing each time and alert_state_o = 1 until rst_ni = 0.
- PauseCycles=5, alert_req_i = 4'b1111 held -> exactly 5 cycles of 0/1 between handshakes.
